// File: rtl/chunked_subtractor_if.sv
// rtl/chunked_subtractor_if.sv - start/busy/done bus between a requester and chunked_subtractor
// The overflow signal exists only when SUB_OVERFLOW_EN is defined.
interface chunked_subtractor_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SUB_OVERFLOW_EN
   logic             overflow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, overflow
   );
`else
   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out
   );
`endif
endinterface

// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - multi-cycle a-b, CHUNK bits per clock with a registered borrow
// Optional SUB_OVERFLOW_EN adds a registered signed-overflow output.
module chunked_subtractor #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   chunked_subtractor_if.slave bus
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e            state_q;
   logic [IDXW-1:0]   idx_q;
   logic              borrow_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  diff_q;
   logic              borrow_out_q;
   logic              busy_q;
   logic              done_q;
`ifdef SUB_OVERFLOW_EN
   logic              overflow_q;
   logic              overflow_d;
`endif

   logic [CHUNK-1:0]  a_chunk;
   logic [CHUNK-1:0]  b_chunk;
   logic [CHUNK:0]    sub_d;
   logic              last_chunk;

   assign a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
   assign b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
   // Top bit of the CHUNK+1 wide result is the borrow into the next chunk.
   assign sub_d      = {1'b0, a_chunk} - {1'b0, b_chunk} - (CHUNK+1)'(borrow_q);
   assign last_chunk = (idx_q == IDXW'(N-1));

`ifdef SUB_OVERFLOW_EN
   // On the last chunk, sub_d[CHUNK-1] is the MSB of the final difference.
   assign overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_d[CHUNK-1] != a_q[WIDTH-1]);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         borrow_q     <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         overflow_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  a_q      <= bus.a;
                  b_q      <= bus.b;
                  borrow_q <= 1'b0;
                  idx_q    <= '0;
                  diff_q   <= '0;
                  state_q  <= S_RUN;
                  busy_q   <= 1'b1;
               end else begin
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
               end
               done_q <= 1'b0;
            end
            S_RUN: begin
               diff_q[idx_q*CHUNK +: CHUNK] <= sub_d[CHUNK-1:0];
               borrow_q <= sub_d[CHUNK];
               if (last_chunk) begin
                  idx_q        <= '0;
                  borrow_out_q <= sub_d[CHUNK];
`ifdef SUB_OVERFLOW_EN
                  overflow_q   <= overflow_d;
`endif
                  state_q      <= S_DONE;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
               end else begin
                  idx_q <= idx_q + IDXW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
   assign bus.overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb/tb_chunked_subtractor.sv - scoreboard bench for chunked_subtractor
module tb_chunked_subtractor;

   localparam int WIDTH = 64;

   typedef struct packed {
      logic             ovf;
      logic             bout;
      logic [WIDTH-1:0] diff;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   int   done_cnt = 0;
   exp_t exp_q[$];

   chunked_subtractor_if #(.WIDTH(WIDTH)) bus ();

   chunked_subtractor #(.WIDTH(WIDTH), .CHUNK(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v);
      exp_t e;
      e.diff = ta - tb_v;
      e.bout = (ta < tb_v);
      e.ovf  = (ta[WIDTH-1] != tb_v[WIDTH-1]) && (e.diff[WIDTH-1] != ta[WIDTH-1]);
      exp_q.push_back(e);
   endtask

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("diff", bus.diff, e.diff);
            check("borrow_out", bus.borrow_out, e.bout);
`ifdef SUB_OVERFLOW_EN
            check("overflow", bus.overflow, e.ovf);
`endif
         end
      end
   end

   task automatic wait_done(output int cyc, output int bc);
      cyc = 0;
      bc  = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         if (bus.busy === 1'b1) bc++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v);
      int cyc, bc;
      @(negedge clk);
      bus.a = ta; bus.b = tb_v; bus.start = 1'b1;
      push_exp(ta, tb_v);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc, bc);
      check("latency", cyc, 8);
      check("busy_cycles", bc, 8);
      @(negedge clk);
      check("done_pulse", bus.done, 0);
      check("busy_after", bus.busy, 0);
   endtask

   initial begin
      int cyc, bc, dc;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_diff", bus.diff, 0);
      check("rst_borrow", bus.borrow_out, 0);
      rst_n = 1'b1;

      run_op(64'd5, 64'd3);
      run_op(64'd0, 64'd1);
      run_op(64'h0000_0001_0000_0000, 64'd1);
      for (int i = 0; i < 4; i++) run_op({$urandom, $urandom}, {$urandom, $urandom});

      // start pulsed mid-RUN with new operands must be ignored
      dc = done_cnt;
      @(negedge clk);
      bus.a = 64'd10; bus.b = 64'd4; bus.start = 1'b1;
      push_exp(64'd10, 64'd4);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.a = 64'd100; bus.b = 64'd1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.a = 64'd55; bus.b = 64'd66;
      wait_done(cyc, bc);
      check("midrun_done_seen", bus.done, 1);
      repeat (15) @(negedge clk);
      check("midrun_done_count", done_cnt - dc, 1);
      check("midrun_idle", bus.busy, 0);

      // reset during the 3rd RUN cycle aborts the operation
      dc = done_cnt;
      bus.a = '1; bus.b = 64'd1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_diff", bus.diff, 0);
      check("abort_borrow", bus.borrow_out, 0);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("abort_no_done", done_cnt - dc, 0);

      // back-to-back: start held, second operands presented on the done cycle
      bus.a = 64'd7; bus.b = 64'd2; bus.start = 1'b1;
      push_exp(64'd7, 64'd2);
      @(negedge clk);
      wait_done(cyc, bc);
      check("b2b_first_latency", cyc, 8);
      bus.a = 64'd2; bus.b = 64'd7;
      push_exp(64'd2, 64'd7);
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_no_idle", bus.busy, 1);
      wait_done(cyc, bc);
      check("b2b_second_latency", cyc, 8);
      check("b2b_diff", bus.diff, 64'hFFFF_FFFF_FFFF_FFFB);
      check("b2b_borrow", bus.borrow_out, 1);
      @(negedge clk);

`ifdef SUB_OVERFLOW_EN
      run_op(64'h8000_0000_0000_0000, 64'd1);
      check("ovf_set", bus.overflow, 1);
      check("ovf_diff", bus.diff, 64'h7FFF_FFFF_FFFF_FFFF);
      run_op(64'd5, 64'd3);
      check("ovf_clear", bus.overflow, 0);
`endif

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
